// File: rtl/hls_txn_profiler.sv
// rtl/hls_txn_profiler.sv - ap_ctrl_hs/ap_ctrl_chain transaction profiler with record FIFO
// Optional per-record done-without-continue stall counter: define PROF_STALL_CNT_EN.
module hls_txn_profiler #(
    parameter int CNT_W      = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int SEQ_W      = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ap_start,
    input  logic             ap_ready,
    input  logic             ap_done,
    input  logic             ap_continue,
    input  logic             finish,
    output logic             rec_valid,
    input  logic             rec_ready,
    output logic [CNT_W-1:0] rec_latency,
    output logic [CNT_W-1:0] rec_interval,
    output logic [SEQ_W-1:0] rec_seq,
    output logic             rec_partial,
    output logic [CNT_W-1:0] rec_stall,
    output logic [SEQ_W-1:0] drop_cnt,
    output logic             busy,
    output logic             flushed
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DWAIT, S_FLUSH} state_t;

    state_t           state_q, state_d;
    logic [1:0]       rsync_q;
    logic             active;
    logic [CNT_W-1:0] cyc_q, cyc_d, t_start_q, t_start_d;
    logic [CNT_W-1:0] last_start_q, last_start_d, interval_q, interval_d;
    logic             seen_q, seen_d;
    logic [SEQ_W-1:0] seq_q, seq_d, drop_q, drop_d;
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d, hd;
    logic [AW:0]      count_q, count_d;
    logic             push, pop, full, wr_en, p_part;
    logic [CNT_W-1:0] p_lat, p_int, start_int, lat_now;
    logic             unused_ready;

    logic [CNT_W-1:0] mem_lat  [FIFO_DEPTH];
    logic [CNT_W-1:0] mem_int  [FIFO_DEPTH];
    logic [SEQ_W-1:0] mem_seq  [FIFO_DEPTH];
    logic             mem_part [FIFO_DEPTH];

`ifdef PROF_STALL_CNT_EN
    logic [CNT_W-1:0] stall_q, stall_d, stall_now, p_stall;
    logic             stall_inc;
    logic [CNT_W-1:0] mem_stall [FIFO_DEPTH];

    assign stall_inc = ap_done & ~ap_continue;
    assign stall_now = (&stall_q) ? stall_q : stall_q + CNT_W'(stall_inc);
`endif

    assign unused_ready = ap_ready;
    assign active       = rsync_q[1];
    assign lat_now      = cyc_q - t_start_q + CNT_W'(1);
    assign start_int    = seen_q ? cyc_q - last_start_q : '0;

    // Release from reset only after two clean edges; assertion stays asynchronous.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) rsync_q <= 2'b00;
        else        rsync_q <= {rsync_q[0], 1'b1};
    end

    always_comb begin
        state_d      = state_q;
        cyc_d        = cyc_q + CNT_W'(1);
        t_start_d    = t_start_q;
        last_start_d = last_start_q;
        interval_d   = interval_q;
        seen_d       = seen_q;
        push         = 1'b0;
        p_lat        = lat_now;
        p_int        = interval_q;
        p_part       = 1'b0;
`ifdef PROF_STALL_CNT_EN
        stall_d      = stall_now;
        p_stall      = stall_now;
`endif
        case (state_q)
            S_IDLE: begin
                if (finish) begin
                    state_d = S_FLUSH;
                end else if (ap_start) begin
                    t_start_d    = cyc_q;
                    last_start_d = cyc_q;
                    seen_d       = 1'b1;
                    interval_d   = start_int;
`ifdef PROF_STALL_CNT_EN
                    stall_d      = CNT_W'(stall_inc);
                    p_stall      = CNT_W'(stall_inc);
`endif
                    if (ap_done && ap_continue) begin
                        push  = 1'b1;
                        p_lat = CNT_W'(1);
                        p_int = start_int;
                    end else if (ap_done) begin
                        state_d = S_DWAIT;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN, S_DWAIT: begin
                if (finish) begin
                    push    = 1'b1;
                    p_part  = 1'b1;
                    state_d = S_FLUSH;
                end else if (ap_continue && (ap_done || state_q == S_DWAIT)) begin
                    push    = 1'b1;
                    state_d = S_IDLE;
                end else if (ap_done) begin
                    state_d = S_DWAIT;
                end
            end
            default: state_d = S_FLUSH;
        endcase

        // A pop in the same cycle frees the slot a push into a full FIFO needs.
        wr_en   = push & (~full | pop);
        count_d = count_q + (AW+1)'(wr_en) - (AW+1)'(pop);
        wr_d    = wr_q + AW'(wr_en);
        rd_d    = rd_q + AW'(pop);
        seq_d   = push ? seq_q + SEQ_W'(1) : seq_q;
        drop_d  = (push && !wr_en && !(&drop_q)) ? drop_q + SEQ_W'(1) : drop_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            cyc_q        <= '0;
            t_start_q    <= '0;
            last_start_q <= '0;
            interval_q   <= '0;
            seen_q       <= 1'b0;
            seq_q        <= '0;
            drop_q       <= '0;
            wr_q         <= '0;
            rd_q         <= '0;
            count_q      <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_lat[i]  <= '0;
                mem_int[i]  <= '0;
                mem_seq[i]  <= '0;
                mem_part[i] <= 1'b0;
`ifdef PROF_STALL_CNT_EN
                mem_stall[i] <= '0;
`endif
            end
`ifdef PROF_STALL_CNT_EN
            stall_q      <= '0;
`endif
        end else if (active) begin
            state_q      <= state_d;
            cyc_q        <= cyc_d;
            t_start_q    <= t_start_d;
            last_start_q <= last_start_d;
            interval_q   <= interval_d;
            seen_q       <= seen_d;
            seq_q        <= seq_d;
            drop_q       <= drop_d;
            wr_q         <= wr_d;
            rd_q         <= rd_d;
            count_q      <= count_d;
`ifdef PROF_STALL_CNT_EN
            stall_q      <= stall_d;
`endif
            if (wr_en) begin
                mem_lat[wr_q]  <= p_lat;
                mem_int[wr_q]  <= p_int;
                mem_seq[wr_q]  <= seq_q;
                mem_part[wr_q] <= p_part;
`ifdef PROF_STALL_CNT_EN
                mem_stall[wr_q] <= p_stall;
`endif
            end
        end
    end

    assign rec_valid = (count_q != '0);
    assign full      = (count_q == (AW+1)'(FIFO_DEPTH));
    assign pop       = rec_valid & rec_ready;

    // When empty, show the slot behind the head so fields keep the last popped record.
    assign hd           = rec_valid ? rd_q : rd_q - AW'(1);
    assign rec_latency  = mem_lat[hd];
    assign rec_interval = mem_int[hd];
    assign rec_seq      = mem_seq[hd];
    assign rec_partial  = mem_part[hd];
`ifdef PROF_STALL_CNT_EN
    assign rec_stall    = mem_stall[hd];
`else
    assign rec_stall    = '0;
`endif
    assign drop_cnt     = drop_q;
    assign busy         = (state_q == S_RUN) || (state_q == S_DWAIT);
    assign flushed      = (state_q == S_FLUSH) && !rec_valid;

endmodule

// File: tb/tb_hls_txn_profiler.sv
// tb/tb_hls_txn_profiler.sv - directed scoreboard bench for hls_txn_profiler
module tb_hls_txn_profiler;
    localparam int DEPTH = 8;
`ifdef PROF_STALL_CNT_EN
    localparam bit STALL_ON = 1'b1;
`else
    localparam bit STALL_ON = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        ap_start = 1'b0, ap_ready = 1'b0, ap_done = 1'b0, ap_continue = 1'b1;
    logic        finish = 1'b0, rec_ready = 1'b1;
    logic        rec_valid, rec_partial, busy, flushed;
    logic [31:0] rec_latency, rec_interval, rec_stall;
    logic [15:0] rec_seq, drop_cnt;

    typedef struct {
        logic [31:0] lat;
        logic [31:0] intv;
        logic [15:0] seq;
        logic        part;
        logic [31:0] stall;
    } rec_t;

    rec_t        sb[$];
    rec_t        pend_rec;
    bit          pend, first;
    int          total, bad, bcyc, last_start;
    logic [15:0] exp_seq, exp_drop, last_seq;
    logic [31:0] iv;

    hls_txn_profiler #(.CNT_W(32), .FIFO_DEPTH(DEPTH), .SEQ_W(16)) dut (
        .clock(clock), .reset(reset), .ap_start(ap_start), .ap_ready(ap_ready),
        .ap_done(ap_done), .ap_continue(ap_continue), .finish(finish),
        .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_latency(rec_latency),
        .rec_interval(rec_interval), .rec_seq(rec_seq), .rec_partial(rec_partial),
        .rec_stall(rec_stall), .drop_cnt(drop_cnt), .busy(busy), .flushed(flushed)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, rec_valid, 1'b0);
        check({tag, "_latency"}, rec_latency, 32'd0);
        check({tag, "_interval"}, rec_interval, 32'd0);
        check({tag, "_seq"}, rec_seq, 16'd0);
        check({tag, "_partial"}, rec_partial, 1'b0);
        check({tag, "_stall"}, rec_stall, 32'd0);
        check({tag, "_drop"}, drop_cnt, 16'd0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_flushed"}, flushed, 1'b0);
    endtask

    // Compare the head before the edge that pops it, then account for this edge's push.
    task automatic tick();
        rec_t e;
        if (rec_valid === 1'b1 && rec_ready === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_rec", rec_valid, 1'b0);
            end else begin
                e = sb.pop_front();
                check("rec_latency", rec_latency, e.lat);
                check("rec_interval", rec_interval, e.intv);
                check("rec_seq", rec_seq, e.seq);
                check("rec_partial", rec_partial, e.part);
                check("rec_stall", rec_stall, e.stall);
                last_seq = e.seq;
            end
        end
        if (pend) begin
            pend = 1'b0;
            if (sb.size() < DEPTH) sb.push_back(pend_rec);
            else if (exp_drop != 16'hffff) exp_drop++;
        end
        @(posedge clock);
        #1;
        bcyc++;
    endtask

    task automatic note_start(output logic [31:0] v);
        v = first ? 32'd0 : 32'(bcyc - last_start);
        last_start = bcyc;
        first = 1'b0;
    endtask

    task automatic queue_rec(input logic [31:0] lat, input logic [31:0] v,
                             input logic part, input logic [31:0] stall);
        pend = 1'b1;
        pend_rec = '{lat, v, exp_seq, part, stall};
        exp_seq++;
    endtask

    // Start at k=0, done from k=b, continue withheld for s cycles, done+continue at k=b+s.
    task automatic txn(input int b, input int s);
        logic [31:0] v;
        v = '0;
        for (int k = 0; k <= b + s; k++) begin
            ap_start    = (k == 0);
            ap_done     = (k >= b);
            ap_continue = (k == b + s);
            if (k == 0) note_start(v);
            if (k == b + s) queue_rec(32'(b + s + 1), v, 1'b0, STALL_ON ? 32'(s) : 32'd0);
            tick();
        end
        ap_start = 1'b0;
        ap_done = 1'b0;
        ap_continue = 1'b1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        ap_start = 1'b0; ap_done = 1'b0; ap_continue = 1'b1; finish = 1'b0; rec_ready = 1'b1;
        sb.delete();
        pend = 1'b0; first = 1'b1; exp_seq = '0; exp_drop = '0; last_seq = '0;
        repeat (2) @(posedge clock);
        #1;
        check_zero("reset");
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
    endtask

    task automatic drain();
        rec_ready = 1'b1;
        for (int i = 0; i < 40 && sb.size() != 0; i++) tick();
        check("drained", {rec_valid, sb.size() == 0}, 2'b01);
    endtask

    initial begin
        total = 0; bad = 0; bcyc = 0; last_start = 0;
        do_reset();
        repeat (3) tick();

        // single transaction, latency 5, first interval 0
        txn(4, 0);
        check("t1_valid_next", rec_valid, 1'b1);
        check("t1_latency", rec_latency, 32'd5);
        check("t1_seq", rec_seq, 16'd0);
        check("t1_interval", rec_interval, 32'd0);
        drain();

        // starts 20 cycles apart, 3-cycle latency each
        txn(2, 0);
        repeat (17) tick();
        txn(2, 0);
        check("t2_interval", rec_interval, 32'd20);
        check("t2_latency", rec_latency, 32'd3);
        drain();

        // start+done in one cycle, back-to-back
        txn(0, 0);
        check("t3_busy", busy, 1'b0);
        txn(0, 0);
        check("t3_interval", rec_interval, 32'd1);
        check("t3_latency", rec_latency, 32'd1);
        drain();

        // done held 4 cycles without continue
        txn(1, 4);
        check("t4_latency", rec_latency, 32'd6);
        check("t4_stall", rec_stall, STALL_ON ? 32'd4 : 32'd0);
        drain();

        // overflow with consumer stalled, then push coinciding with pop
        rec_ready = 1'b0;
        repeat (10) txn(0, 0);
        check("t5_drop", drop_cnt, 16'd2);
        check("t5_head_seq", rec_seq, sb[0].seq);
        repeat (3) tick();
        check("t5_stable_seq", rec_seq, sb[0].seq);
        check("t5_stable_valid", rec_valid, 1'b1);
        rec_ready = 1'b1;
        txn(0, 0);
        check("t5_push_on_pop", drop_cnt, exp_drop);
        check("t5_drop_hold", drop_cnt, 16'd2);
        drain();
        check("t5_hold_last", rec_seq, last_seq);

        // finish mid-transaction
        ap_start = 1'b1;
        note_start(iv);
        tick();
        ap_start = 1'b0;
        repeat (4) tick();
        check("t6_busy", busy, 1'b1);
        finish = 1'b1;
        rec_ready = 1'b0;
        queue_rec(32'd6, iv, 1'b1, 32'd0);
        tick();
        finish = 1'b0;
        check("t6_partial", rec_partial, 1'b1);
        check("t6_latency", rec_latency, 32'd6);
        check("t6_not_flushed", flushed, 1'b0);
        ap_start = 1'b1; ap_done = 1'b1;
        tick();
        ap_start = 1'b0; ap_done = 1'b0;
        repeat (3) tick();
        check("t6_ignored_busy", busy, 1'b0);
        rec_ready = 1'b1;
        tick();
        check("t6_flushed", flushed, 1'b1);
        drain();

        // asynchronous reset in the middle of RUN
        do_reset();
        rec_ready = 1'b0;
        txn(0, 0);
        ap_start = 1'b1;
        tick();
        ap_start = 1'b0;
        tick();
        check("t7_busy", busy, 1'b1);
        check("t7_valid", rec_valid, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        check_zero("async_reset");
        do_reset();

        // first transaction after reset starts from clean counters
        txn(3, 0);
        check("t8_interval", rec_interval, 32'd0);
        check("t8_seq", rec_seq, 16'd0);
        check("t8_latency", rec_latency, 32'd4);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/hls_txn_profiler.md
Name: hls_txn_profiler

Overview:
- Synthesizable transaction profiler for one block-level HLS module (ap_ctrl_hs / ap_ctrl_chain), e.g. cnn_lenet top, the Layer2/Layer3 pipelined loop submodules, or SIGMOID.
- Sits directly upstream of the dataflow monitor/CSV dump path. It watches ap_start/ap_ready/ap_done/ap_continue, timestamps each transaction, and queues records for the consumer through a valid/ready FIFO.
- Usable in simulation and on-board, where the RTL it replaces is class-based and simulation-only.

Parameters:
- CNT_W, 32: width of cycle counter, latency and interval fields.
- FIFO_DEPTH, 8: record FIFO depth; power of two, at least 2.
- SEQ_W, 16: width of transaction sequence number and drop counter.

Ports:
- clock  in  1  sole clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- ap_start  in  1  observed module start.
- ap_ready  in  1  observed module ready.
- ap_done  in  1  observed module done.
- ap_continue  in  1  observed continue; tie 1 for ap_ctrl_hs modules.
- finish  in  1  end-of-simulation/run request.
- rec_valid  out  1  record available at FIFO head.
- rec_ready  in  1  consumer accepts the head record.
- rec_latency  out  CNT_W  cycles from start to done, inclusive.
- rec_interval  out  CNT_W  start-to-start distance; 0 for the first transaction.
- rec_seq  out  SEQ_W  transaction index, starting at 0.
- rec_partial  out  1  record truncated by finish.
- rec_stall  out  CNT_W  done-held-without-continue cycles (see optional feature).
- drop_cnt  out  SEQ_W  records lost because the FIFO was full; saturating.
- busy  out  1  transaction in flight.
- flushed  out  1  finish seen and FIFO drained.

Behaviour:
- Reset (reset=0, async):
  - All outputs 0; FIFO emptied.
  - cyc, seq, drop_cnt and the first-flag cleared; FSM to IDLE.
  - Deassertion is synchronised internally (2-flop) before leaving reset.
- cyc: free-running CNT_W counter, wraps modulo 2^CNT_W. All differences are modulo 2^CNT_W, so wrap is transparent.
- FSM states: IDLE, RUN, DWAIT, FLUSH.
- IDLE:
  - ap_start=1: capture t_start=cyc. interval = cyc - last_start, or 0 if this is the first transaction. last_start=cyc.
  - If ap_done=1 and ap_continue=1 in the same cycle: push a record with latency=1 and stay in IDLE.
  - Else if ap_done=1: go to DWAIT.
  - Else: go to RUN.
- RUN:
  - ap_done=1 and ap_continue=1: push latency = cyc - t_start + 1; go to IDLE.
  - ap_done=1 and ap_continue=0: go to DWAIT.
- DWAIT: on ap_continue=1, push the record with latency measured to that cycle; go to IDLE.
- ap_ready is not used for latency. ap_start held high across back-to-back transactions counts as a new start in the cycle the FSM returns to IDLE and ap_start=1.
- finish=1 in any state:
  - If in RUN or DWAIT, push a record with rec_partial=1 and latency to the current cycle.
  - Go to FLUSH. FLUSH captures no further transactions.
  - finish is sticky until reset.
- flushed = FLUSH state and FIFO empty.
- busy = (state == RUN or DWAIT).
- Push path:
  - Record written at the push cycle N; rec_valid visible at N+1.
  - seq increments on every attempted push, including dropped ones.
- FIFO full on push:
  - Record dropped; drop_cnt += 1, saturating at all-ones.
  - Exception: a simultaneous pop (rec_valid and rec_ready) frees a slot, so the push is accepted.
- Pop: when rec_valid and rec_ready, advance the head. rec_* outputs are stable while rec_valid=1 and rec_ready=0.
- Empty: rec_valid=0; rec_* fields hold their last values.

Optional Feature:
- Macro: PROF_STALL_CNT_EN.
- Defined: rec_stall counts cycles with ap_done=1 and ap_continue=0 during the transaction, saturating at all-ones, and is stored per record.
- Undefined: rec_stall is tied to 0, no counter or FIFO storage is generated, and all other behaviour is identical.

Test Plan:
- Start at cyc=10, done+continue at cyc=14 -> one record: latency=5, interval=0, seq=0, rec_valid at cyc=15.
- Starts at cyc 10 and 30, each with 3-cycle latency -> second record: interval=20, latency=3, seq=1.
- ap_start and ap_done together (latency 1) -> latency=1, FSM stays IDLE; a following start 1 cycle later -> interval=1.
- rec_ready=0, 10 transactions, FIFO_DEPTH=8 -> 8 records kept (seq 0-7), drop_cnt=2; push coinciding with a pop while full -> accepted.
- ap_done held 4 cycles with ap_continue=0, then continue -> latency includes the wait; rec_stall=4 with PROF_STALL_CNT_EN, 0 without.
- finish at cyc=50 mid-transaction started at 45 -> partial record (rec_partial=1, latency=6); later starts ignored; flushed=1 after the pop. Reset pulse mid-RUN -> all outputs 0 immediately.
